// File: rtl/cost_epoch_ctrl_pkg.sv
// Shared definitions for the training-epoch cost controller: state encodings,
// default fixed-point format and the fixed-point ONE constant.
package cost_epoch_ctrl_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 24;

    localparam logic [DEF_WIDTH-1:0] FX_ONE = DEF_WIDTH'(1) << DEF_FRAC;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_CLEAR = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN,
        LATCH = ST_LATCH,
        CLEAR = ST_CLEAR
    } state_t;

endpackage

// File: rtl/cost_epoch_ctrl_sample_counter.sv
// Mod-N up-counter for samples within an epoch; flags the last sample slot.
module cost_epoch_ctrl_sample_counter #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] count;

    assign tc = (count == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/cost_epoch_ctrl.sv
// Epoch sequencer for the cost accumulator: gathers N_SAMPLE accepted samples,
// latches the mean cost, tests convergence and either loops or finishes.
module cost_epoch_ctrl
    import cost_epoch_ctrl_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int FRAC        = DEF_FRAC,
    parameter int N_SAMPLE    = 4,
    parameter int LOG2_SAMPLE = 2,
    parameter int MAX_EPOCH   = 1024,
    parameter int EPOCH_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [WIDTH-1:0]   i_thresh,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_acc_en,
    output logic               o_acc_clr,
    input  logic [WIDTH-1:0]   i_acc_cost,
    output logic [WIDTH-1:0]   o_cost,
    output logic [EPOCH_W-1:0] o_epoch,
    output logic               o_done,
    output logic               o_converged,
    output logic               o_finish,
    output logic               o_busy
);

    if (FRAC >= WIDTH || (1 << LOG2_SAMPLE) != N_SAMPLE) begin : g_bad_params
        $error("cost_epoch_ctrl: inconsistent FRAC/WIDTH or N_SAMPLE/LOG2_SAMPLE");
    end

    state_t state, state_nx;
    logic [WIDTH-1:0]        thresh_q;
    logic                    abort_clr_q;
    logic                    accept;
    logic                    last_sample;
    logic                    start_ok;
    logic                    limit_hit;
    logic                    conv_nx;
    logic signed [WIDTH-1:0] mean;

    assign accept    = i_valid & o_ready;
    assign start_ok  = (state == IDLE) && i_start && !i_abort;
    assign limit_hit = (o_epoch == EPOCH_W'(MAX_EPOCH));
    assign mean      = $signed(i_acc_cost) >>> LOG2_SAMPLE;
    assign conv_nx   = (mean < $signed(thresh_q));

    assign o_acc_en  = accept;
    assign o_busy    = (state != IDLE);
    // Abort clears one cycle late (registered); start and CLEAR clear in-cycle.
    assign o_acc_clr = !rst || abort_clr_q || (state == CLEAR) || start_ok;

    cost_epoch_ctrl_sample_counter #(
        .N  (N_SAMPLE),
        .CW (LOG2_SAMPLE)
    ) u_sample_counter (
        .clk (clk),
        .rst (rst),
        .clr ((state != RUN) || i_abort),
        .en  (accept),
        .tc  (last_sample)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        o_ready  = 1'b0;
        case (state)
            IDLE:    if (start_ok) state_nx = RUN;
            RUN: begin
                o_ready = 1'b1;
                if (accept && last_sample) state_nx = DRAIN;
            end
            DRAIN:   state_nx = LATCH;
            LATCH:   state_nx = CLEAR;
            CLEAR:   state_nx = (o_converged || limit_hit) ? IDLE : RUN;
            default: state_nx = IDLE;
        endcase
        if (state != IDLE && i_abort) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            thresh_q    <= '0;
            abort_clr_q <= 1'b0;
            o_cost      <= '0;
            o_epoch     <= '0;
            o_converged <= 1'b0;
            o_done      <= 1'b0;
            o_finish    <= 1'b0;
        end else begin
            abort_clr_q <= i_abort && (state != IDLE);
            o_done      <= 1'b0;
            o_finish    <= 1'b0;
            if (start_ok) begin
                thresh_q    <= i_thresh;
                o_epoch     <= '0;
                o_converged <= 1'b0;
            end
            if (state == LATCH && !i_abort) begin
                o_cost      <= mean;
                o_epoch     <= (o_epoch == '1) ? o_epoch : o_epoch + 1'b1;
                o_converged <= conv_nx;
                o_done      <= 1'b1;
            end
            if (state == CLEAR && !i_abort && (o_converged || limit_hit)) begin
                o_finish <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cost_epoch_ctrl.sv
// Scoreboard bench for cost_epoch_ctrl with a behavioural accumulator model.
module tb_cost_epoch_ctrl;
    import cost_epoch_ctrl_pkg::*;

    localparam int WIDTH   = 32;
    localparam int EPOCH_W = 16;
    localparam logic [WIDTH-1:0] THRESH_HALF = FX_ONE >> 1;

    logic               clk;
    logic               rst;
    logic               i_start;
    logic               i_abort;
    logic [WIDTH-1:0]   i_thresh;
    logic               i_valid;
    logic               o_ready;
    logic               o_acc_en;
    logic               o_acc_clr;
    logic [WIDTH-1:0]   i_acc_cost;
    logic [WIDTH-1:0]   o_cost;
    logic [EPOCH_W-1:0] o_epoch;
    logic               o_done;
    logic               o_converged;
    logic               o_finish;
    logic               o_busy;

    typedef struct packed {
        logic [WIDTH-1:0]   cost;
        logic [EPOCH_W-1:0] epoch;
        logic               conv;
    } exp_t;

    exp_t done_q[$];
    exp_t fin_q[$];

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int en_count = 0;
    int last_accept = 0;
    logic [WIDTH-1:0] sample_val;
    logic [WIDTH-1:0] acc;

    cost_epoch_ctrl #(
        .WIDTH(WIDTH), .FRAC(24), .N_SAMPLE(4), .LOG2_SAMPLE(2),
        .MAX_EPOCH(3), .EPOCH_W(EPOCH_W)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
        .i_thresh(i_thresh), .i_valid(i_valid), .o_ready(o_ready),
        .o_acc_en(o_acc_en), .o_acc_clr(o_acc_clr), .i_acc_cost(i_acc_cost),
        .o_cost(o_cost), .o_epoch(o_epoch), .o_done(o_done),
        .o_converged(o_converged), .o_finish(o_finish), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        if (o_acc_clr) acc <= '0;
        else if (o_acc_en) acc <= acc + sample_val;
    end
    assign i_acc_cost = acc;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops expectations whenever the DUT reports an epoch result or run end.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (o_acc_en) begin
                en_count++;
                last_accept = cycle + 1;
            end
            if (o_done) begin
                if (done_q.size() == 0) begin
                    checkOutput("unexpected_done", 32'(o_done), 0);
                end else begin
                    e = done_q.pop_front();
                    checkOutput("cost", o_cost, e.cost);
                    checkOutput("epoch", 32'(o_epoch), 32'(e.epoch));
                    checkOutput("converged", 32'(o_converged), 32'(e.conv));
                    checkOutput("accepts_per_epoch", en_count, 4);
                    checkOutput("done_latency", cycle - last_accept, 2);
                end
                en_count = 0;
            end
            if (o_finish) begin
                if (fin_q.size() == 0) begin
                    checkOutput("unexpected_finish", 32'(o_finish), 0);
                end else begin
                    e = fin_q.pop_front();
                    checkOutput("finish_epoch", 32'(o_epoch), 32'(e.epoch));
                    checkOutput("finish_converged", 32'(o_converged), 32'(e.conv));
                    checkOutput("finish_busy", 32'(o_busy), 0);
                end
            end
        end
    end

    task automatic startRun(input logic [WIDTH-1:0] th);
        i_thresh = th;
        i_start  = 1'b1;
        en_count = 0;
        @(negedge clk);
        checkOutput("start_clr", 32'(o_acc_clr), 1);
        tick();
        i_start = 1'b0;
        @(negedge clk);
        checkOutput("run_busy", 32'(o_busy), 1);
        checkOutput("run_ready", 32'(o_ready), 1);
        tick();
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] val, input bit gaps, input int n);
        int got = 0;
        int guard = 0;
        bit tog = 1'b1;
        sample_val = val;
        while (got < n && guard < 40) begin
            i_valid = gaps ? tog : 1'b1;
            @(negedge clk);
            if (i_valid && o_ready) got++;
            tick();
            tog = ~tog;
            guard++;
        end
        i_valid = 1'b0;
        checkOutput("samples_accepted", got, n);
    endtask

    task automatic checkDrain();
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            @(negedge clk);
            checkOutput("stall_ready", 32'(o_ready), 0);
            checkOutput("stall_acc_en", 32'(o_acc_en), 0);
            if (k == 2) checkOutput("clear_pulse", 32'(o_acc_clr), 1);
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int g = 0;
        while (o_busy && g < 20) begin
            tick();
            g++;
        end
        checkOutput("idle_reached", 32'(o_busy), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b0; i_start = 1'b1; i_abort = 1'b0; i_valid = 1'b0;
        i_thresh = THRESH_HALF; sample_val = '0;
        tick();
        tick();
        @(negedge clk);
        checkOutput("rst_acc_clr", 32'(o_acc_clr), 1);
        checkOutput("rst_busy", 32'(o_busy), 0);
        checkOutput("rst_ready", 32'(o_ready), 0);
        checkOutput("rst_cost", o_cost, 0);
        checkOutput("rst_epoch", 32'(o_epoch), 0);
        checkOutput("rst_conv", 32'(o_converged), 0);
        checkOutput("rst_done", 32'(o_done), 0);
        checkOutput("rst_finish", 32'(o_finish), 0);
        rst = 1'b1; i_start = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("idle_after_rst", 32'(o_busy), 0);
        checkOutput("idle_no_clr", 32'(o_acc_clr), 0);
        tick();

        $display("[TB] basic epoch then convergence");
        startRun(THRESH_HALF);
        done_q.push_back('{cost: 32'h0100_0000, epoch: 16'd1, conv: 1'b0});
        applyStimulus(32'h0100_0000, 1'b0, 4);
        checkDrain();
        @(negedge clk);
        checkOutput("rerun_ready", 32'(o_ready), 1);
        checkOutput("rerun_epoch", 32'(o_epoch), 1);
        tick();
        done_q.push_back('{cost: 32'h0040_0000, epoch: 16'd2, conv: 1'b1});
        fin_q.push_back('{cost: 32'h0040_0000, epoch: 16'd2, conv: 1'b1});
        applyStimulus(32'h0040_0000, 1'b0, 4);
        waitIdle();
        @(negedge clk);
        checkOutput("sticky_conv", 32'(o_converged), 1);
        checkOutput("held_cost", o_cost, 32'h0040_0000);
        tick();

        $display("[TB] gapped input, abort, abort+start");
        startRun(THRESH_HALF);
        done_q.push_back('{cost: 32'h0100_0000, epoch: 16'd1, conv: 1'b0});
        applyStimulus(32'h0100_0000, 1'b1, 4);
        checkDrain();
        applyStimulus(32'h0100_0000, 1'b0, 2);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_idle", 32'(o_busy), 0);
        checkOutput("abort_clr", 32'(o_acc_clr), 1);
        checkOutput("abort_cost_kept", o_cost, 32'h0100_0000);
        checkOutput("abort_epoch_kept", 32'(o_epoch), 1);
        tick();
        @(negedge clk);
        checkOutput("abort_clr_once", 32'(o_acc_clr), 0);
        tick();
        i_abort = 1'b1; i_start = 1'b1;
        tick();
        i_abort = 1'b0; i_start = 1'b0;
        @(negedge clk);
        checkOutput("abort_beats_start", 32'(o_busy), 0);
        tick();
        startRun(THRESH_HALF);
        done_q.push_back('{cost: 32'h0100_0000, epoch: 16'd1, conv: 1'b0});
        applyStimulus(32'h0100_0000, 1'b0, 4);
        checkDrain();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        @(negedge clk);
        checkOutput("abort2_idle", 32'(o_busy), 0);
        tick();

        $display("[TB] epoch limit");
        startRun(THRESH_HALF);
        fin_q.push_back('{cost: 32'h0200_0000, epoch: 16'd3, conv: 1'b0});
        for (int e = 1; e <= 3; e++) begin
            done_q.push_back('{cost: 32'h0200_0000, epoch: EPOCH_W'(e), conv: 1'b0});
            applyStimulus(32'h0200_0000, 1'b0, 4);
            if (e < 3) checkDrain();
        end
        waitIdle();
        @(negedge clk);
        checkOutput("limit_epoch", 32'(o_epoch), 3);
        tick();

        $display("[TB] reset mid-run");
        startRun(THRESH_HALF);
        applyStimulus(32'h0100_0000, 1'b0, 2);
        rst = 1'b0; i_start = 1'b1;
        @(negedge clk);
        checkOutput("midrst_clr", 32'(o_acc_clr), 1);
        tick();
        @(negedge clk);
        checkOutput("midrst_busy", 32'(o_busy), 0);
        checkOutput("midrst_cost", o_cost, 0);
        checkOutput("midrst_epoch", 32'(o_epoch), 0);
        checkOutput("midrst_clr_held", 32'(o_acc_clr), 1);
        rst = 1'b1; i_start = 1'b0; en_count = 0;
        tick();
        @(negedge clk);
        checkOutput("start_ignored_in_rst", 32'(o_busy), 0);
        checkOutput("post_rst_no_clr", 32'(o_acc_clr), 0);
        tick();

        checkOutput("pending_done", done_q.size(), 0);
        checkOutput("pending_finish", fin_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cost_epoch_ctrl.md
Name: cost_epoch_ctrl

Overview:
- Sequences the cost accumulator over training epochs of N_SAMPLE samples.
- Accepts per-sample output deltas over a valid/ready handshake and issues one-cycle accumulate enables.
- At epoch end, latches the mean cost, compares it to a convergence threshold, clears the accumulator, and either starts the next epoch or finishes.
- Sits between the output-layer delta stage and the cost accumulator; the training top-level reads its status.

Parameters:
WIDTH, 32, data word width (signed fixed point)
FRAC, 24, fractional bits of cost/threshold
N_SAMPLE, 4, samples per epoch (power of two, >=2)
LOG2_SAMPLE, 2, log2(N_SAMPLE); used for mean shift
MAX_EPOCH, 1024, epoch limit before forced finish
EPOCH_W, 16, epoch counter width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
i_start  in  1  pulse; begin training run (honoured only in IDLE)
i_abort  in  1  pulse; abandon run, clear accumulator, return to IDLE
i_thresh  in  WIDTH  convergence threshold, sampled at i_start
i_valid  in  1  sample delta vector valid
o_ready  out  1  controller accepts a sample this cycle
o_acc_en  out  1  accumulator enable (sample contributes)
o_acc_clr  out  1  accumulator clear, one cycle
i_acc_cost  in  WIDTH  accumulator running-sum output
o_cost  out  WIDTH  latched mean epoch cost
o_epoch  out  EPOCH_W  completed epoch count
o_done  out  1  one-cycle pulse when o_cost updates
o_converged  out  1  sticky: last mean cost < threshold
o_finish  out  1  one-cycle pulse at end of run
o_busy  out  1  high in any state except IDLE

Behaviour:
- One clock. Reset is synchronous and active-low: rst==0 sampled at a clk edge resets the block.
- Reset values: state=IDLE; o_cost, o_epoch, o_converged, all counters = 0; o_acc_clr=1 while rst is low (accumulator held clear); all other outputs = 0.
- States:
  - IDLE: o_ready=0. On i_start: capture i_thresh, zero o_epoch and o_converged, pulse o_acc_clr, go to RUN.
  - RUN: o_ready=1. A sample is accepted on (i_valid & o_ready); o_acc_en = i_valid & o_ready, combinational, same cycle. Sample counter increments on each accept. On the N_SAMPLE-th accept go to DRAIN; o_ready is 0 in the cycle after.
  - DRAIN: one cycle, o_ready=0; covers the accumulator register latency so i_acc_cost holds the full epoch sum. Go to LATCH.
  - LATCH:
    - o_cost <= i_acc_cost >>> LOG2_SAMPLE (arithmetic shift; no rounding).
    - o_epoch <= o_epoch+1, saturating at all-ones.
    - o_converged <= (signed compare: shifted cost < thresh).
    - o_done pulses this cycle. Go to CLEAR.
  - CLEAR: o_acc_clr=1 for one cycle; sample counter <= 0.
    - If converged or o_epoch==MAX_EPOCH: pulse o_finish, go to IDLE.
    - Otherwise go to RUN.
- Latency: o_done is asserted 2 cycles after the clock edge accepting the last sample. Minimum epoch length is N_SAMPLE+3 cycles.
- i_start outside IDLE is ignored.
- i_abort has priority over all transitions in any non-IDLE state. Next cycle: state=IDLE, o_acc_clr=1 for one cycle, no o_done/o_finish. o_cost and o_epoch keep their last values.
- i_abort and i_start in the same cycle while in IDLE: abort wins and the start is dropped.
- i_valid while o_ready=0: the sample is not consumed; the source must hold it.
- Reset mid-epoch: all state is lost, and the accumulator stays cleared while rst is low.
- Negative sum (should not occur, since the sum is of squares): shifted arithmetically and passed through; no saturation.

Decomposition:
- Shared include/package holds:
  - state encodings (IDLE, RUN, DRAIN, LATCH, CLEAR) as 3-bit localparams;
  - default WIDTH/FRAC;
  - a fixed-point ONE constant (1<<FRAC).
- One sub-module: sample_counter (mod-N_SAMPLE up-counter with sync clear, enable, and a terminal-count flag). Everything else stays inline.

Test Plan:
- Basic epoch: N_SAMPLE=4, thresh=0x0080_0000 (0.5); feed 4 samples back-to-back; accumulator model sums to 0x0400_0000 -> o_cost=0x0100_0000, o_epoch=1, o_done 2 cycles after the last accept, o_converged=0, o_acc_clr pulse, back to RUN.
- Convergence: second epoch sum 0x0100_0000 -> o_cost=0x0040_0000 < thresh -> o_converged=1, o_finish pulse, IDLE, o_busy=0.
- Backpressure/gaps: i_valid toggled 1,0,1,0...; check o_acc_en exactly 4 times per epoch and o_ready=0 throughout DRAIN/LATCH/CLEAR with i_valid held high.
- Epoch limit: MAX_EPOCH=3, sum always 0x0800_0000 -> three o_done pulses, o_epoch=3, o_finish with o_converged=0.
- Abort: i_abort after 2 accepts -> next cycle IDLE, o_acc_clr=1 for one cycle, no o_done; a subsequent i_start runs a clean epoch with o_epoch=1.
- Reset mid-RUN: drive rst=0 for one cycle -> all outputs zero, o_acc_clr high during reset; i_start ignored while rst=0.
